// File: rtl/mem8_arb.sv
// Two-requester byte-RAM arbiter: core (port 0) normally wins, host (port 1) gets forced
// priority after MAX_WAIT starved cycles and may lock the port for bursts. Optional grant
// counters are built when MEM8_ARB_STAT_EN is defined.
module mem8_arb #(
  parameter int ASZ      = 17,
  parameter int MAX_WAIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           we0,
  input  logic [ASZ-1:0] addr0,
  input  logic [7:0]     wdata0,
  output logic           ack0,
  output logic           rvld0,
  output logic [7:0]     rdata0,
  input  logic           req1,
  input  logic           we1,
  input  logic           lock1,
  input  logic [ASZ-1:0] addr1,
  input  logic [7:0]     wdata1,
  output logic           ack1,
  output logic           rvld1,
  output logic [7:0]     rdata1,
  output logic [ASZ-1:0] mem_addr,
  output logic           mem_we,
  output logic [7:0]     mem_wdata,
  input  logic [7:0]     mem_rdata
`ifdef MEM8_ARB_STAT_EN
  ,
  output logic [31:0]    gnt_cnt0,
  output logic [31:0]    gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wait1;
  logic [7:0] hold0, hold1;

  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr0;
    mem_wdata = wdata0;
    case (state)
      OWN0: begin
        ack0   = req0;
        mem_we = req0 & we0;
      end
      OWN1: begin
        ack1      = req1;
        mem_we    = req1 & we1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
      end
      default: ;
    endcase
  end

  // Lock only counts while port 1 already owns the RAM.
  always_comb begin
    state_nxt = IDLE;
    if (state == OWN1 && req1 && lock1)
      state_nxt = OWN1;
    else if (req1 && wait1 >= WAIT_MAX)
      state_nxt = OWN1;
    else if (req0)
      state_nxt = OWN0;
    else if (req1)
      state_nxt = OWN1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait1 <= '0;
    else if (ack1 || !req1)
      wait1 <= '0;
    else if (wait1 < WAIT_MAX)
      wait1 <= wait1 + 8'd1;
  end

  // RAM data arrives one cycle after the address; hold it for the requester afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvld0 <= 1'b0;
      rvld1 <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      rvld0 <= ack0 & ~we0;
      rvld1 <= ack1 & ~we1;
      if (rvld0) hold0 <= mem_rdata;
      if (rvld1) hold1 <= mem_rdata;
    end
  end

  assign rdata0 = rvld0 ? mem_rdata : hold0;
  assign rdata1 = rvld1 ? mem_rdata : hold1;

`ifdef MEM8_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (ack0) gnt_cnt0 <= gnt_cnt0 + 32'd1;
      if (ack1) gnt_cnt1 <= gnt_cnt1 + 32'd1;
    end
  end
`else
  // Grant statistics not built.
`endif

endmodule

// File: tb/tb_mem8_arb.sv
// Directed bench for mem8_arb with a behavioural byte RAM (one-cycle read latency).
module tb_mem8_arb;
  localparam int ASZ = 17;

  logic           clk, rst_n;
  logic           req0, we0, ack0, rvld0;
  logic [ASZ-1:0] addr0;
  logic [7:0]     wdata0, rdata0;
  logic           req1, we1, lock1, ack1, rvld1;
  logic [ASZ-1:0] addr1;
  logic [7:0]     wdata1, rdata1;
  logic [ASZ-1:0] mem_addr;
  logic           mem_we;
  logic [7:0]     mem_wdata, mem_rdata;
`ifdef MEM8_ARB_STAT_EN
  logic [31:0]    gnt_cnt0, gnt_cnt1;
`endif

  logic [7:0] ram [0:(1<<ASZ)-1];
  int n_cmp = 0;
  int n_err = 0;
  int n_ack1;

  mem8_arb #(.ASZ(ASZ), .MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvld0(rvld0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvld1(rvld1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEM8_ARB_STAT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic core_read(input logic [ASZ-1:0] a, input logic [7:0] exp);
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = a;
    @(negedge clk); chk("rd0_no_ack_first", 32'(ack0), 32'd1 - 32'd1);
    tick();
    @(negedge clk); chk("rd0_ack", 32'(ack0), 32'd1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd0_rvld", 32'(rvld0), 32'd1);
    chk("rd0_data", 32'(rdata0), 32'(exp));
  endtask

  task automatic host_write(input logic [ASZ-1:0] a, input logic [7:0] d);
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
    @(negedge clk); chk("wr1_no_ack_first", 32'(ack1), 32'd0);
    tick();
    @(negedge clk);
    chk("wr1_ack", 32'(ack1), 32'd1);
    chk("wr1_mem_we", 32'(mem_we), 32'd1);
    chk("wr1_mem_addr", 32'(mem_addr), 32'(a));
    tick();
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk); chk("wr1_no_rvld", 32'(rvld1), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 16; i++) ram[17'h1000 + 17'(i)] = 8'h41 + 8'(i);
    ram[17'h1400] = 8'h00;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvld0", 32'(rvld0), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    tick();
    rst_n = 1'b1;

    // core read, then host write followed by core read-back
    core_read(17'h1000, 8'h41);
    tick();
    @(negedge clk);
    chk("rd0_rvld_drop", 32'(rvld0), 32'd0);
    chk("rd0_data_hold", 32'(rdata0), 32'h41);
    host_write(17'h1400, 8'h2E);
    core_read(17'h1400, 8'h2E);

    // starvation: core holds req0, host raised for one access
    tick();
    req0 = 1'b1; addr0 = 17'h1004; we0 = 1'b0;
    tick();
    tick();
    req1 = 1'b1; addr1 = 17'h1001; we1 = 1'b0;
    n_ack1 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) req1 = 1'b0;
      @(negedge clk);
      if (ack1) n_ack1++;
      if (k <= 8) chk("starve_core_owns", 32'(ack0), 32'd1);
      if (k == 9) chk("starve_ack1_cycle9", 32'(ack1), 32'd1);
      if (k == 10) chk("starve_rdata1", 32'(rdata1), 32'h42);
      if (k == 11) chk("starve_core_resumes", 32'(ack0), 32'd1);
    end
    chk("starve_ack1_once", 32'(n_ack1), 32'd1);
    tick();
    req0 = 1'b0;
    tick();

    // locked host burst against a continuously requesting core
    tick();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 17'h1000;
    tick();
    req0 = 1'b1; addr0 = 17'h1008;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("burst_ack1_not_ack0", 32'({ack1, ack0}), 32'b10);
      if (i > 0) chk("burst_rdata1", 32'({rvld1, rdata1}), 32'h100 + 32'h41 + 32'(i - 1));
      tick();
      if (i < 15) addr1 = 17'h1000 + 17'(i + 1);
      else begin
        req1 = 1'b0; lock1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("burst_last_data", 32'({rvld1, rdata1}), 32'h150);
    tick();
    @(negedge clk);
    chk("burst_core_resumes", 32'(ack0), 32'd1);
    tick();
    req0 = 1'b0;
    tick();

    // reset in the middle of a locked host read burst
    tick();
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 17'h1002;
    tick();
    tick();
    @(negedge clk);
    chk("prerst_ack1_rvld1", 32'({ack1, rvld1}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("inrst_ack1", 32'(ack1), 32'd0);
    chk("inrst_mem_we", 32'(mem_we), 32'd0);
    chk("inrst_rvld1", 32'(rvld1), 32'd0);
    chk("inrst_rdata1", 32'(rdata1), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_no_ack1", 32'(ack1), 32'd0);
    tick();
    @(negedge clk);
    chk("postrst_ack1", 32'(ack1), 32'd1);
    tick();
    req1 = 1'b0; lock1 = 1'b0;
    tick();

    // fresh reset, then 5 core and 3 host accesses for the grant counters
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) core_read(17'h1000 + 17'(j), 8'h41 + 8'(j));
    for (int j = 0; j < 3; j++) host_write(17'h1500 + 17'(j), 8'h90 + 8'(j));
    tick();
    tick();
`ifdef MEM8_ARB_STAT_EN
    chk("gnt_cnt0", gnt_cnt0, 32'd5);
    chk("gnt_cnt1", gnt_cnt1, 32'd3);
`endif
    core_read(17'h1501, 8'h91);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem8_arb.md
MEM8_ARB -- requirements
Module: mem8_arb

Interface
REQ-001 Parameter ASZ, 17, byte address width (128K space).
REQ-002 Parameter MAX_WAIT, 8, cycles requester 1 may be starved before it gets forced priority (range 1..255).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0, we0  input  1 each  core (eJ32) request / write strobe.
REQ-006 addr0  input  ASZ  core byte address; wdata0  input  8  core write byte.
REQ-007 ack0  output  1  core access issued this cycle; rvld0  output  1  core read data valid; rdata0  output  8  core read byte.
REQ-008 req1, we1, lock1  input  1 each  host/loader/dump request, write strobe, burst lock.
REQ-009 addr1  input  ASZ; wdata1  input  8  host address / write byte.
REQ-010 ack1, rvld1  output  1 each; rdata1  output  8  host handshake and read byte.
REQ-011 mem_addr  output  ASZ; mem_we  output  1; mem_wdata  output  8  single-port byte RAM command.
REQ-012 mem_rdata  input  8  RAM read byte, valid the cycle after the address is presented.

Function
REQ-013 State register SHALL hold one of IDLE, OWN0, OWN1; the RAM port SHALL be driven combinationally from the owner's addr/we/wdata.
REQ-014 In OWN0: ackN/mem_we per owner — ack0 = req0, mem_we = req0 & we0; ack1 = 0. OWN1 symmetric; IDLE: ack0 = ack1 = 0, mem_we = 0, mem_addr = addr0.
REQ-015 Next state is computed every edge: if state=OWN1 and req1 and lock1 -> OWN1; else if req1 and wait1 >= MAX_WAIT -> OWN1; else if req0 -> OWN0; else if req1 -> OWN1; else IDLE.
REQ-016 Consequently a new request is acked no earlier than the cycle after req first asserts; an owner holding req high gets back-to-back acks, one byte per cycle.
REQ-017 rvldN SHALL be a register: rvldN <= ackN & ~weN; rdataN SHALL equal mem_rdata while rvldN = 1 and hold last value otherwise.
REQ-018 wait1 (8-bit) SHALL increment each cycle req1 = 1 and ack1 = 0, saturate at MAX_WAIT, and clear to 0 on any cycle ack1 = 1 or req1 = 0.
REQ-019 Both requesting with wait1 < MAX_WAIT: requester 0 wins; with wait1 = MAX_WAIT: requester 1 wins even if OWN0 is current.
REQ-020 lock1 while not owner SHALL have no effect; lock1 held by owner SHALL block requester 0 indefinitely (host responsibility to bound bursts).
REQ-021 Requester dropping req while owner SHALL release the port at the next edge with no ack issued in the dropped cycle.
REQ-022 Requesters SHALL hold addr/we/wdata stable from req rise until the ack cycle; arbiter performs no internal buffering.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, wait1=0, rvld0=rvld1=0, rdata0=rdata1=0, ack0=ack1=0, mem_we=0.
REQ-024 A transaction interrupted by reset is lost; a req still high after rst_n rises SHALL be arbitrated as new (ack earliest one cycle after release).

Configuration
REQ-025 Macro MEM8_ARB_STAT_EN: when defined, 32-bit outputs gnt_cnt0/gnt_cnt1 SHALL count ack0/ack1 cycles, wrap at 2^32, reset to 0.
REQ-026 Without MEM8_ARB_STAT_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-027 Reset: rst_n=0 mid OWN1 burst -> same-cycle ack1=0, mem_we=0, rvld1=0; after release req1 high -> ack1 one cycle later.
REQ-028 Core read: preload 0x1000=0x41, req0 addr0=0x1000 -> ack0 next cycle, rvld0=1 with rdata0=0x41 cycle after.
REQ-029 Host write then core read: req1 we1 addr1=0x1400 wdata1=0x2E acked; core reads 0x1400 -> 0x2E.
REQ-030 Starvation: req0 held continuously, req1 raised -> ack1 exactly once after wait1 reaches 8 (9th cycle after req1 rise), then OWN0 resumes.
REQ-031 Lock burst: host lock1 with 16 sequential reads 0x1000..0x100F while req0 high -> 16 consecutive ack1, ack0=0 throughout, data matches RAM.
REQ-032 Stats (MEM8_ARB_STAT_EN): 5 core + 3 host accesses -> gnt_cnt0=5, gnt_cnt1=3.
